// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-stated word memory answering the CPU MAR/data/cs/we/oe bus with a ready pulse.
// Define MEM_BUS_RESPONDER_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_bus_responder #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] OOR_VALUE = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    output logic                  ready,
    output logic                  err
`ifdef MEM_BUS_RESPONDER_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    cap_we;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rdata_valid;
    logic [CW-1:0]           wait_cnt;
    logic [DATA_WIDTH-1:0]   mem [2**MEM_ADDR_BITS];
    logic                    in_range;
    logic [MEM_ADDR_BITS-1:0] idx;
    assign in_range = ~|cap_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
    assign idx = cap_addr[MEM_ADDR_BITS-1:0];
    // Only a read with output enable may drive; oe together with we stays off the bus.
    assign data = (cs && oe && !we && rdata_valid) ? rdata : 'z;
    always_ff @(posedge clk)
        if (state == ACCESS && cap_we && in_range) mem[idx] <= cap_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wait_cnt    <= '0;
            cap_addr    <= '0;
            cap_we      <= 1'b0;
            cap_data    <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: if (cs) begin
                    cap_addr <= addr;
                    cap_we   <= we;
                    cap_data <= data;
                    wait_cnt <= CW'(WAIT_CYCLES - 1);
                    state    <= WAIT_CYCLES > 0 ? WAIT : ACCESS;
                end
                WAIT: if (wait_cnt == '0) state <= ACCESS;
                      else wait_cnt <= wait_cnt - 1'b1;
                ACCESS: begin
                    if (!cap_we) begin
                        rdata       <= in_range ? mem[idx] : OOR_VALUE;
                        rdata_valid <= 1'b1;
                    end
                    ready <= 1'b1;
                    err   <= !in_range;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MEM_BUS_RESPONDER_STATS_EN
    // Out-of-range writes still count as completed writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == ACCESS) begin
            if (!cap_we && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
            if (cap_we && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
        end
    end
`endif
endmodule
